writeback_unit: RTL and testbench
=================================

WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, register data width; only 32 is supported.
REQ-002 Parameter ADDRESS_WIDTH, default 5, register address width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset; synchronous and active-low, sampled on the clk rising edge.
REQ-005 alu_valid  in  1  ALU result present this cycle.
REQ-006 alu_rd  in  ADDRESS_WIDTH  ALU destination register.
REQ-007 alu_data  in  DATA_WIDTH  ALU result.
REQ-008 alu_ready  out  1  ALU result accepted this cycle (combinational).
REQ-009 ld_issue  in  1  load issued to data memory this cycle.
REQ-010 ld_rd  in  ADDRESS_WIDTH  load destination register.
REQ-011 ld_funct3  in  3  load type: LB=000, LH=001, LW=010, LBU=100, LHU=101.
REQ-012 ld_ready  out  1  load issue may be accepted (combinational).
REQ-013 mem_rvalid  in  1  memory read data returned this cycle, in issue order.
REQ-014 mem_rdata  in  DATA_WIDTH  raw memory word, byte/half in low bits.
REQ-015 we3  out  1  register write enable, registered.
REQ-016 ad3  out  ADDRESS_WIDTH  register write address, registered.
REQ-017 wd3  out  DATA_WIDTH  register write data, registered.
REQ-018 pending_mask  out  2**ADDRESS_WIDTH  bit n set while a load to xn is outstanding.
REQ-019 err_unexp  out  1  sticky: response arrived with no outstanding load.

Function
REQ-020 The block SHALL hold outstanding loads (rd, funct3) in a 2-entry in-order queue; ld_ready = (count < 2).
REQ-021 ld_issue while ld_ready=0 SHALL be ignored; the queue is unchanged.
REQ-022 mem_rvalid with count=0 SHALL be dropped, set err_unexp, and produce no write.
REQ-023 mem_rvalid and ld_issue in the same cycle SHALL both take effect: pop the head, push the new entry, count unchanged (also valid at count=2 only if ld_ready was high, i.e. never).
REQ-024 Arbitration: memory response has priority; alu_ready = !(mem_rvalid && count>0).
REQ-025 An accepted event in cycle N SHALL drive we3/ad3/wd3 in cycle N+1, for exactly one cycle per event.
REQ-026 With no accepted event in cycle N, we3=0 in cycle N+1, and ad3/wd3 hold their previous values.
REQ-027 A load result SHALL be extended per the head funct3:
- LB: sign-extend [7:0]
- LH: sign-extend [15:0]
- LW: full word
- LBU: zero-extend [7:0]
- LHU: zero-extend [15:0]
- other codes: full word
REQ-028 Any event with rd=0 SHALL be consumed (popped or accepted) with we3=0.
REQ-029 pending_mask SHALL be the combinational OR of the one-hot rd of valid queue entries, with bit 0 forced to 0; two loads to the same rd keep the bit set until both retire.
REQ-030 The queue pointer SHALL wrap modulo 2.

Reset
REQ-031 While rst_n=0 at a clk edge: count=0, queue pointers=0, we3=0, ad3=0, wd3=0, err_unexp=0.
REQ-032 Reset mid-operation SHALL discard outstanding loads; a later mem_rvalid with the queue empty follows REQ-022.
REQ-033 err_unexp SHALL clear only on reset.

Structure
REQ-034 Package wb_pkg SHALL hold the load funct3 encodings (enum) and the queue depth constant (2).
REQ-035 The queue SHALL be one sub-module, wb_fifo (2-deep, parameterised width, push/pop/count).

Verification
REQ-036 ALU only: alu_valid=1, rd=5, data=0x1234 at cycle N -> we3=1, ad3=5, wd3=0x1234 at N+1; we3=0 at N+2.
REQ-037 LB to x7, response 0x000000F0 -> wd3=0xFFFFFFF0; same with LBU -> 0x000000F0; LH with 0x00008001 -> 0xFFFF8001.
REQ-038 Two loads to x3 and x4, third ld_issue at count=2 -> ld_ready=0, third ignored; pending_mask=0x18; responses retire x3 then x4; mask returns to 0.
REQ-039 alu_valid and mem_rvalid in the same cycle -> alu_ready=0, load written first; ALU written in the cycle after it is re-presented.
REQ-040 mem_rvalid with empty queue -> err_unexp=1 and no write; LW to x0 -> we3 stays 0, pending_mask bit 0 stays 0.
REQ-041 rst_n=0 for one cycle with 2 loads outstanding -> count=0, pending_mask=0, we3=0; the next mem_rvalid sets err_unexp.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared definitions for the writeback unit: load encodings, queue sizing and
// the load-result extension helper.
package wb_pkg;

   localparam int unsigned QueueDepth = 2;
   localparam int unsigned CountWidth = 2;
   localparam int unsigned Funct3Width = 3;

   typedef enum logic [Funct3Width-1:0] {
      LdLb  = 3'b000,
      LdLh  = 3'b001,
      LdLw  = 3'b010,
      LdLbu = 3'b100,
      LdLhu = 3'b101
   } ld_funct3_e;

   // Narrow loads arrive in the low bits of the raw word.
   function automatic logic [31:0] load_extend(input logic [Funct3Width-1:0] funct3,
                                               input logic [31:0] raw);
      logic [31:0] result;
      case (funct3)
         LdLb:    result = {{24{raw[7]}}, raw[7:0]};
         LdLh:    result = {{16{raw[15]}}, raw[15:0]};
         LdLw:    result = raw;
         LdLbu:   result = {24'h000000, raw[7:0]};
         LdLhu:   result = {16'h0000, raw[15:0]};
         default: result = raw;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// Two-entry in-order queue with push/pop/count and per-slot visibility so the
// owner can derive which entries are live.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             push,
   input  logic                             pop,
   input  logic [WIDTH-1:0]                 wdata,
   output logic [WIDTH-1:0]                 rdata,
   output logic [CountWidth-1:0]            count,
   output logic [QueueDepth-1:0]            slot_valid,
   output logic [QueueDepth-1:0][WIDTH-1:0] slot_data
);

   logic                             wr_ptr_q, wr_ptr_d;
   logic                             rd_ptr_q, rd_ptr_d;
   logic [CountWidth-1:0]            count_q, count_d;
   logic [QueueDepth-1:0][WIDTH-1:0] mem_q;
   logic                             full, empty;
   logic                             do_push, do_pop;

   assign full    = (count_q == CountWidth'(QueueDepth));
   assign empty   = (count_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Pointers are one bit wide, so increment wraps modulo the depth.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

   // With one entry live, only the slot under the read pointer holds it.
   always_comb begin
      slot_valid[0] = full || (!empty && !rd_ptr_q);
      slot_valid[1] = full || (!empty && rd_ptr_q);
   end

   assign rdata     = mem_q[rd_ptr_q];
   assign count     = count_q;
   assign slot_data = mem_q;

endmodule

// File: rtl/writeback_unit.sv
// Register-file writeback arbiter: merges ALU results with in-order load
// responses, extends load data and tracks registers with loads in flight.
module writeback_unit
   import wb_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned ADDRESS_WIDTH = 5
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       alu_valid,
   input  logic [ADDRESS_WIDTH-1:0]   alu_rd,
   input  logic [DATA_WIDTH-1:0]      alu_data,
   output logic                       alu_ready,
   input  logic                       ld_issue,
   input  logic [ADDRESS_WIDTH-1:0]   ld_rd,
   input  logic [2:0]                 ld_funct3,
   output logic                       ld_ready,
   input  logic                       mem_rvalid,
   input  logic [DATA_WIDTH-1:0]      mem_rdata,
   output logic                       we3,
   output logic [ADDRESS_WIDTH-1:0]   ad3,
   output logic [DATA_WIDTH-1:0]      wd3,
   output logic [2**ADDRESS_WIDTH-1:0] pending_mask,
   output logic                       err_unexp
);

   localparam int unsigned EntryWidth = ADDRESS_WIDTH + Funct3Width;

   logic [EntryWidth-1:0]                 push_entry;
   logic [EntryWidth-1:0]                 head_entry;
   logic [ADDRESS_WIDTH-1:0]              head_rd;
   logic [Funct3Width-1:0]                head_funct3;
   logic [CountWidth-1:0]                 count;
   logic [QueueDepth-1:0]                 slot_valid;
   logic [QueueDepth-1:0][EntryWidth-1:0] slot_data;
   logic                                  queue_empty;
   logic                                  resp_take;
   logic                                  alu_take;
   logic                                  ld_push;

   logic                     we3_q, we3_d;
   logic [ADDRESS_WIDTH-1:0] ad3_q, ad3_d;
   logic [DATA_WIDTH-1:0]    wd3_q, wd3_d;
   logic                     err_q, err_d;

   assign push_entry  = {ld_rd, ld_funct3};
   assign head_rd     = head_entry[EntryWidth-1:Funct3Width];
   assign head_funct3 = head_entry[Funct3Width-1:0];
   assign queue_empty = (count == '0);

   assign ld_ready  = (count < CountWidth'(QueueDepth));
   assign ld_push   = ld_issue && ld_ready;
   // Memory responses cannot be stalled, so they win over the ALU.
   assign resp_take = mem_rvalid && !queue_empty;
   assign alu_ready = !resp_take;
   assign alu_take  = alu_valid && alu_ready;

   wb_fifo #(
      .WIDTH(EntryWidth)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (ld_push),
      .pop       (resp_take),
      .wdata     (push_entry),
      .rdata     (head_entry),
      .count     (count),
      .slot_valid(slot_valid),
      .slot_data (slot_data)
   );

   // x0 events are consumed but never raise the write enable.
   always_comb begin
      we3_d = 1'b0;
      ad3_d = ad3_q;
      wd3_d = wd3_q;
      if (resp_take) begin
         we3_d = (head_rd != '0);
         ad3_d = head_rd;
         wd3_d = DATA_WIDTH'(load_extend(head_funct3, 32'(mem_rdata)));
      end else if (alu_take) begin
         we3_d = (alu_rd != '0);
         ad3_d = alu_rd;
         wd3_d = alu_data;
      end
   end

   assign err_d = err_q || (mem_rvalid && queue_empty);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         we3_q <= 1'b0;
         ad3_q <= '0;
         wd3_q <= '0;
         err_q <= 1'b0;
      end else begin
         we3_q <= we3_d;
         ad3_q <= ad3_d;
         wd3_q <= wd3_d;
         err_q <= err_d;
      end
   end

   always_comb begin
      pending_mask = '0;
      for (int i = 0; i < QueueDepth; i++) begin
         if (slot_valid[i]) begin
            pending_mask[slot_data[i][EntryWidth-1:Funct3Width]] = 1'b1;
         end
      end
      pending_mask[0] = 1'b0;
   end

   assign we3       = we3_q;
   assign ad3       = ad3_q;
   assign wd3       = wd3_q;
   assign err_unexp = err_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: directed stimulus pushes expected
// writes, a negedge monitor pops and compares whenever we3 is asserted.
module tb_writeback_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        alu_ready;
   logic        ld_issue;
   logic [4:0]  ld_rd;
   logic [2:0]  ld_funct3;
   logic        ld_ready;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        we3;
   logic [4:0]  ad3;
   logic [31:0] wd3;
   logic [31:0] pending_mask;
   logic        err_unexp;

   typedef struct packed {
      logic [4:0]  ad;
      logic [31:0] wd;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   writeback_unit #(
      .DATA_WIDTH   (32),
      .ADDRESS_WIDTH(5)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .alu_valid   (alu_valid),
      .alu_rd      (alu_rd),
      .alu_data    (alu_data),
      .alu_ready   (alu_ready),
      .ld_issue    (ld_issue),
      .ld_rd       (ld_rd),
      .ld_funct3   (ld_funct3),
      .ld_ready    (ld_ready),
      .mem_rvalid  (mem_rvalid),
      .mem_rdata   (mem_rdata),
      .we3         (we3),
      .ad3         (ad3),
      .wd3         (wd3),
      .pending_mask(pending_mask),
      .err_unexp   (err_unexp)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got 0x%08h expected 0x%08h", name, got, exp);
      end
   endtask

   task automatic expect_write(input logic [4:0] ad, input logic [31:0] wd);
      exp_t e;
      e.ad = ad;
      e.wd = wd;
      sb.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      alu_valid  = 1'b0;
      ld_issue   = 1'b0;
      mem_rvalid = 1'b0;
   endtask

   task automatic issue(input logic [4:0] rd, input logic [2:0] f3);
      ld_issue  = 1'b1;
      ld_rd     = rd;
      ld_funct3 = f3;
      tick();
   endtask

   task automatic respond(input logic [31:0] data);
      mem_rvalid = 1'b1;
      mem_rdata  = data;
      tick();
   endtask

   always @(negedge clk) begin
      if (we3 === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write got ad3=%0d wd3=0x%08h expected no write", ad3, wd3);
         end else begin
            mon_e = sb.pop_front();
            check("write_ad3", 32'(ad3), 32'(mon_e.ad));
            check("write_wd3", wd3, mon_e.wd);
         end
      end
   end

   initial begin
      rst_n      = 1'b0;
      alu_valid  = 1'b0;
      alu_rd     = '0;
      alu_data   = '0;
      ld_issue   = 1'b0;
      ld_rd      = '0;
      ld_funct3  = '0;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      tick();
      tick();
      check("reset_we3", 32'(we3), 32'd0);
      check("reset_ad3", 32'(ad3), 32'd0);
      check("reset_wd3", wd3, 32'd0);
      check("reset_err", 32'(err_unexp), 32'd0);
      check("reset_mask", pending_mask, 32'd0);
      check("reset_ld_ready", 32'(ld_ready), 32'd1);
      rst_n = 1'b1;
      tick();

      // ALU-only write
      alu_valid = 1'b1;
      alu_rd    = 5'd5;
      alu_data  = 32'h0000_1234;
      check("alu_ready_idle", 32'(alu_ready), 32'd1);
      expect_write(5'd5, 32'h0000_1234);
      tick();
      tick();

      // Load extension cases
      issue(5'd7, 3'b000);
      check("mask_lb_x7", pending_mask, 32'h0000_0080);
      expect_write(5'd7, 32'hFFFF_FFF0);
      respond(32'h0000_00F0);
      check("mask_after_lb", pending_mask, 32'd0);
      issue(5'd7, 3'b100);
      expect_write(5'd7, 32'h0000_00F0);
      respond(32'h0000_00F0);
      issue(5'd7, 3'b001);
      expect_write(5'd7, 32'hFFFF_8001);
      respond(32'h0000_8001);
      issue(5'd8, 3'b101);
      expect_write(5'd8, 32'h0000_8001);
      respond(32'hABCD_8001);
      issue(5'd9, 3'b010);
      expect_write(5'd9, 32'hDEAD_BEEF);
      respond(32'hDEAD_BEEF);

      // Full queue ignores a third issue
      issue(5'd3, 3'b010);
      issue(5'd4, 3'b010);
      check("ld_ready_full", 32'(ld_ready), 32'd0);
      check("mask_x3_x4", pending_mask, 32'h0000_0018);
      issue(5'd9, 3'b010);
      check("mask_after_ignored", pending_mask, 32'h0000_0018);
      expect_write(5'd3, 32'h0000_0011);
      respond(32'h0000_0011);
      check("mask_after_x3", pending_mask, 32'h0000_0010);
      check("ld_ready_one", 32'(ld_ready), 32'd1);
      expect_write(5'd4, 32'h0000_0022);
      respond(32'h0000_0022);
      check("mask_drained", pending_mask, 32'd0);
      check("err_after_drain", 32'(err_unexp), 32'd0);

      // ALU vs memory collision: load first, ALU retried
      issue(5'd10, 3'b010);
      alu_valid  = 1'b1;
      alu_rd     = 5'd6;
      alu_data   = 32'h0000_0066;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h0000_0077;
      #1;
      check("alu_ready_collide", 32'(alu_ready), 32'd0);
      expect_write(5'd10, 32'h0000_0077);
      tick();
      alu_valid = 1'b1;
      #1;
      check("alu_ready_retry", 32'(alu_ready), 32'd1);
      expect_write(5'd6, 32'h0000_0066);
      tick();

      // Simultaneous pop and push
      issue(5'd11, 3'b010);
      ld_issue   = 1'b1;
      ld_rd      = 5'd12;
      ld_funct3  = 3'b010;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h0000_ABCD;
      expect_write(5'd11, 32'h0000_ABCD);
      tick();
      check("mask_push_pop", pending_mask, 32'h0000_1000);
      expect_write(5'd12, 32'h0000_1212);
      respond(32'h0000_1212);
      check("mask_after_push_pop", pending_mask, 32'd0);

      // Load to x0: consumed silently
      issue(5'd0, 3'b010);
      check("mask_x0", pending_mask, 32'd0);
      check("ld_ready_x0", 32'(ld_ready), 32'd1);
      respond(32'h0000_0055);
      tick();

      // Unexpected response
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h1111_1111;
      #1;
      check("alu_ready_empty_resp", 32'(alu_ready), 32'd1);
      tick();
      check("err_set", 32'(err_unexp), 32'd1);
      tick();
      tick();
      check("err_sticky", 32'(err_unexp), 32'd1);

      // Reset with two loads outstanding
      issue(5'd13, 3'b010);
      issue(5'd14, 3'b010);
      check("mask_x13_x14", pending_mask, 32'h0000_6000);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("midreset_mask", pending_mask, 32'd0);
      check("midreset_ld_ready", 32'(ld_ready), 32'd1);
      check("midreset_we3", 32'(we3), 32'd0);
      check("midreset_ad3", 32'(ad3), 32'd0);
      check("midreset_wd3", wd3, 32'd0);
      check("midreset_err", 32'(err_unexp), 32'd0);
      respond(32'h0000_0099);
      check("err_after_reset", 32'(err_unexp), 32'd1);
      tick();
      tick();
      tick();
      check("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
